stim_sequencer: RTL

//  Programmable, timed stimulus player for the core's external control inputs (sigCH, sigCP, buttons).

---
 rtl/stim_sequencer_pkg.sv | 28 ++
 rtl/stim_sequencer_tick_gen.sv | 31 +++
 rtl/stim_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/stim_sequencer_pkg.sv
// Shared types and helpers for the stimulus sequencer.
// Optional feature macro: STIM_SEQ_LOOP_EN (looped playback).
package stim_sequencer_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int NUM_EV_DEF  = 8;
  localparam int DELAY_W_DEF = 16;

  typedef logic [NUM_CH_DEF-1:0]  stim_value_t;
  typedef logic [DELAY_W_DEF-1:0] stim_delay_t;

  typedef struct packed {
    stim_delay_t delay;
    stim_value_t value;
  } stim_event_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stim_state_e;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stim_sequencer_tick_gen.sv
// Core-cycle tick generator: divides clkX4 by CYC_DIV, with a synchronous clear
// that restarts the tick phase.
module stim_sequencer_tick_gen
  import stim_sequencer_pkg::*;
#(
  parameter int CYC_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = clog2_min1(CYC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYC_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/stim_sequencer.sv
// Timed stimulus player: replays a {delay, value} table onto outSig, with delays in core-cycle ticks.
// Define STIM_SEQ_LOOP_EN to replay the table continuously until abort.
module stim_sequencer
  import stim_sequencer_pkg::*;
#(
  parameter int                NUM_CH   = 4,
  parameter int                NUM_EV   = 8,
  parameter int                DELAY_W  = 16,
  parameter int                CYC_DIV  = 4,
  parameter int                CNT_W    = 32,
  parameter logic [NUM_CH-1:0] INIT_VAL = '1
) (
  input  logic                      clkX4,
  input  logic                      rst,
  input  logic                      cfgWe,
  input  logic [$clog2(NUM_EV)-1:0] cfgAddr,
  input  logic [DELAY_W-1:0]        cfgDelay,
  input  logic [NUM_CH-1:0]         cfgValue,
  input  logic [$clog2(NUM_EV):0]   cfgLen,
  input  logic                      start,
  input  logic                      abort,
  output logic [NUM_CH-1:0]         outSig,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_EV)-1:0] evIndex,
  output logic [CNT_W-1:0]          cycleCount
);

  localparam int IDX_W = $clog2(NUM_EV);
  localparam int LEN_W = IDX_W + 1;

  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [NUM_CH-1:0]  value;
  } ev_t;

  ev_t tbl [NUM_EV];

  stim_state_e        state_q, state_d;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DELAY_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               div_clr;
  logic               tick;
  logic [IDX_W-1:0]   idx_nxt;
  logic               is_last;

  stim_sequencer_tick_gen #(.CYC_DIV(CYC_DIV)) u_tick (
    .clk  (clkX4),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  // Table is writable only while not playing, so a run never sees a half-edited program.
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EV; i++) tbl[i] <= '0;
    end else if (cfgWe && state_q != ST_RUN) begin
      tbl[cfgAddr] <= {cfgDelay, cfgValue};
    end
  end

  assign idx_nxt = idx_q + IDX_W'(1);
  assign is_last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    cyc_d   = cyc_q;
    len_d   = len_q;
    div_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          div_clr = 1'b1;
          len_d   = (cfgLen > LEN_W'(NUM_EV)) ? LEN_W'(NUM_EV) : cfgLen;
          idx_d   = '0;
          rem_d   = tbl[0].delay;
          cyc_d   = '0;
          state_d = (cfgLen == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q != '0) begin
          if (tick) begin
            rem_d = rem_q - DELAY_W'(1);
            cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
          end
        end else begin
          out_d = tbl[idx_q].value;
          if (is_last) begin
`ifdef STIM_SEQ_LOOP_EN
            // Restart the tick phase so every pass has the same timing as the first.
            idx_d   = '0;
            rem_d   = tbl[0].delay;
            div_clr = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = idx_nxt;
            rem_d = tbl[idx_nxt].delay;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      out_q <= INIT_VAL;
      idx_q <= '0;
      rem_q <= '0;
      cyc_q <= '0;
      len_q <= '0;
    end else begin
      out_q <= out_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      cyc_q <= cyc_d;
      len_q <= len_d;
    end
  end

  // busy/done together decode the full FSM state (neither set = IDLE).
  assign outSig     = out_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign evIndex    = idx_q;
  assign cycleCount = cyc_q;

endmodule
